// File: rtl/medidor_pkg.sv
// Shared types and sizing helpers for the ultrasonic range meter.
package medidor_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    DISPARO,
    ESPERA_ECO,
    MEDE_ECO,
    INTERVALO
  } estado_t;

  localparam logic [7:0] DIST_MAX = 8'd255;

  // Counter width able to hold 0..n-1, derived from the longest interval it must span.
  function automatic int largura_contador(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/medidor_distancia_ultrassom_if.sv
// Sensor-side signal bundle of the ultrasonic range meter (master = meter, slave = sensor/consumer).
interface medidor_distancia_ultrassom_if;
  logic       echo;
  logic       trig;
  logic [7:0] distancia_cm;
  logic       valido;
  logic       timeout;
  logic       ocupado;

  modport master (input echo, output trig, distancia_cm, valido, timeout, ocupado);
  modport slave  (output echo, input trig, distancia_cm, valido, timeout, ocupado);
endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-high reset.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sinc_q;

  // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;
endmodule

// File: rtl/medidor_distancia_ultrassom.sv
// Ultrasonic range meter: periodic trig pulse, echo timing, conversion to whole cm without a divider.
// Define FILTRO_MEDIA_EN to average the last four valid samples on distancia_cm.
module medidor_distancia_ultrassom
  import medidor_pkg::*;
#(
  parameter int TRIG_CYCLES    = 1000,
  parameter int CYCLES_PER_CM  = 5800,
  parameter int TIMEOUT_CYCLES = 3_000_000,
  parameter int PERIOD_CYCLES  = 6_000_000
) (
  input logic clk,
  input logic rst,
  medidor_distancia_ultrassom_if.master sensor
);
  localparam int CNT_W = largura_contador(PERIOD_CYCLES);
  localparam int PRE_W = largura_contador(CYCLES_PER_CM);
  localparam logic [CNT_W-1:0] TRIG_FIM    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PERIODO_FIM = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_FIM     = PRE_W'(CYCLES_PER_CM - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] periodo_q, periodo_d;
  logic [CNT_W-1:0] espera_q, espera_d;
  logic [PRE_W-1:0] presc_q, presc_d, presc_base, presc_passo;
  logic [7:0]       cm_q, cm_d, cm_base, cm_passo;
  logic             echo_s, echo_ant_q, subida, descida;
  logic             trig_q, ocupado_q, timeout_q, timeout_d;
  logic             amostra_ok;
  logic [7:0]       distancia_q;
  logic             valido_q;

  sincronizador_2ff u_sinc_echo (
    .clk (clk),
    .rst (rst),
    .d_i (sensor.echo),
    .q_o (echo_s)
  );

  assign subida  = echo_s & ~echo_ant_q;
  assign descida = ~echo_s & echo_ant_q;

  // One prescaler step; the rise cycle itself is the first counted echo cycle.
  // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
  always_comb begin
    presc_base  = (estado_q == MEDE_ECO) ? presc_q : '0;
    cm_base     = (estado_q == MEDE_ECO) ? cm_q : '0;
    presc_passo = presc_base + 1'b1;
    cm_passo    = cm_base;
    if (presc_base == PRE_FIM) begin
      presc_passo = '0;
      if (cm_base != DIST_MAX) cm_passo = cm_base + 8'd1;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    periodo_d  = periodo_q + 1'b1;
    espera_d   = '0;
    presc_d    = presc_q;
    cm_d       = cm_q;
    timeout_d  = timeout_q;
    amostra_ok = 1'b0;
    unique case (estado_q)
      OCIOSO:  estado_d = DISPARO;
      DISPARO: if (periodo_q == TRIG_FIM) estado_d = ESPERA_ECO;
      ESPERA_ECO: begin
        espera_d = espera_q + 1'b1;
        if (subida) begin
          estado_d = MEDE_ECO;
          presc_d  = presc_passo;
          cm_d     = cm_passo;
        end else if (espera_q == TIMEOUT_LIM) begin
          timeout_d = 1'b1;
          estado_d  = INTERVALO;
        end
      end
      MEDE_ECO: begin
        espera_d = espera_q + 1'b1;
        presc_d  = presc_passo;
        cm_d     = cm_passo;
        if (descida) begin
          amostra_ok = 1'b1;
          timeout_d  = 1'b0;
          estado_d   = INTERVALO;
        end else if (espera_q == TIMEOUT_LIM) begin
          timeout_d = 1'b1;
          estado_d  = INTERVALO;
        end
      end
      INTERVALO: if (periodo_q >= PERIODO_FIM) estado_d = DISPARO;
      default:   estado_d = OCIOSO;
    endcase
    if (estado_d == DISPARO && estado_q != DISPARO) periodo_d = '0;
  end

  // trig is retimed one cycle so the sensor pin is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      periodo_q  <= '0;
      espera_q   <= '0;
      presc_q    <= '0;
      cm_q       <= '0;
      echo_ant_q <= 1'b0;
      trig_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      periodo_q  <= periodo_d;
      espera_q   <= espera_d;
      presc_q    <= presc_d;
      cm_q       <= cm_d;
      echo_ant_q <= echo_s;
      trig_q     <= (estado_q == DISPARO);
      ocupado_q  <= (estado_d inside {DISPARO, ESPERA_ECO, MEDE_ECO});
      timeout_q  <= timeout_d;
    end
  end

`ifdef FILTRO_MEDIA_EN
  logic [7:0] hist_q [4];
  logic       pend_q;
  logic [9:0] soma;

  always_comb soma = 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'(hist_q[3]);

  // NOTE: the history is four plain flops, not a RAM, so it is reset to give a defined average after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      pend_q      <= 1'b0;
      valido_q    <= 1'b0;
      distancia_q <= '0;
    end else begin
      pend_q   <= amostra_ok;
      valido_q <= pend_q;
      if (amostra_ok) begin
        hist_q[0] <= cm_q;
        hist_q[1] <= hist_q[0];
        hist_q[2] <= hist_q[1];
        hist_q[3] <= hist_q[2];
      end
      if (pend_q) distancia_q <= soma[9:2];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      valido_q    <= 1'b0;
      distancia_q <= '0;
    end else begin
      valido_q <= amostra_ok;
      if (amostra_ok) distancia_q <= cm_q;
    end
  end
`endif

  assign sensor.trig         = trig_q;
  assign sensor.distancia_cm = distancia_q;
  assign sensor.valido       = valido_q;
  assign sensor.timeout      = timeout_q;
  assign sensor.ocupado      = ocupado_q;
endmodule

// File: tb/tb_medidor_distancia_ultrassom.sv
// Directed bench for medidor_distancia_ultrassom with shortened timing parameters.
module tb_medidor_distancia_ultrassom;
  logic clk;
  logic rst;

  medidor_distancia_ultrassom_if bus ();

  medidor_distancia_ultrassom #(
    .TRIG_CYCLES    (4),
    .CYCLES_PER_CM  (10),
    .TIMEOUT_CYCLES (5000),
    .PERIOD_CYCLES  (8000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sensor (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_pass   = 0;
  int n_ciclo  = 0;
  int n_valido = 0;
  int t_timeout = 0;
  int dist_esp = 0;
  bit timeout_visto = 1'b0;

`ifdef FILTRO_MEDIA_EN
  int hist_m [4];
  int esp7 [4] = '{5, 10, 20, 30};
  int larg7 [4] = '{200, 200, 400, 400};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    n_ciclo++;
    if (bus.valido === 1'b1) n_valido++;
    if (bus.timeout === 1'b1 && !timeout_visto) begin
      timeout_visto = 1'b1;
      t_timeout = n_ciclo;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic modelo_reset();
`ifdef FILTRO_MEDIA_EN
    for (int i = 0; i < 4; i++) hist_m[i] = 0;
`endif
    dist_esp = 0;
  endtask

  task automatic modelo(input int raw, output int esp);
`ifdef FILTRO_MEDIA_EN
    hist_m[3] = hist_m[2];
    hist_m[2] = hist_m[1];
    hist_m[1] = hist_m[0];
    hist_m[0] = raw;
    esp = (hist_m[0] + hist_m[1] + hist_m[2] + hist_m[3]) >> 2;
`else
    esp = raw;
`endif
  endtask

  // Waits for a full trig pulse; returns at the first sample after its fall.
  task automatic esperar_trig(output int t_sub, output bit ok);
    int n = 0;
    ok = 1'b0;
    t_sub = 0;
    while (bus.trig !== 1'b1 && n < 10000) begin tick(); n++; end
    if (bus.trig === 1'b1) begin
      t_sub = n_ciclo;
      while (bus.trig === 1'b1 && n < 10000) begin tick(); n++; end
      ok = (bus.trig === 1'b0);
    end
  endtask

  task automatic esperar_valido(input int budget, output bit ok);
    int n = 0;
    while (bus.valido !== 1'b1 && n < budget) begin tick(); n++; end
    ok = (bus.valido === 1'b1);
  endtask

  task automatic medida(input int atraso, input int largura, input string tag);
    bit ok;
    int raw;
    ticks(atraso);
    n_valido = 0;
    bus.echo = 1'b1;
    ticks(largura);
    bus.echo = 1'b0;
    check({tag, "_ocupado"}, bus.ocupado, 1);
    esperar_valido(50, ok);
    check({tag, "_valido"}, ok, 1);
    raw = largura / 10;
    if (raw > 255) raw = 255;
    modelo(raw, dist_esp);
    check({tag, "_dist"}, bus.distancia_cm, dist_esp);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_livre"}, bus.ocupado, 0);
    tick();
    check({tag, "_pulso_unico"}, n_valido, 1);
  endtask

  initial begin
    int r_ant, r, t_tf, t_rel, largura;
    bit ok;

    // 1: reset values and first trig pulse
    rst = 1'b1;
    bus.echo = 1'b0;
    modelo_reset();
    ticks(3);
    check("rst_trig", bus.trig, 0);
    check("rst_dist", bus.distancia_cm, 0);
    check("rst_valido", bus.valido, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_ocupado", bus.ocupado, 0);
    rst = 1'b0;
    tick();
    check("trig_antes", bus.trig, 0);
    tick();
    check("trig_sobe", bus.trig, 1);
    check("ocupado_disparo", bus.ocupado, 1);
    r_ant = n_ciclo;
    largura = 1;
    while (bus.trig === 1'b1 && largura < 100) begin
      tick();
      if (bus.trig === 1'b1) largura++;
    end
    check("trig_largura", largura, 4);

    // 2: 200-cycle echo -> 20 cm
    medida(49, 200, "eco200");

    // 3: 3000-cycle echo saturates at 255
    esperar_trig(r, ok);
    check("trig3_ok", ok, 1);
    check("periodo3", r - r_ant, 8000);
    r_ant = r;
    medida(19, 3000, "eco3000");

    // 4: echo never rises -> timeout, then a valid echo clears it
    esperar_trig(r, ok);
    check("trig4_ok", ok, 1);
    check("periodo4", r - r_ant, 8000);
    r_ant = r;
    t_tf = n_ciclo;
    timeout_visto = 1'b0;
    n_valido = 0;
    ticks(6000);
    check("to4_visto", timeout_visto, 1);
    check("to4_instante", t_timeout - t_tf, 5000);
    check("to4_sem_valido", n_valido, 0);
    check("to4_dist_mantida", bus.distancia_cm, dist_esp);
    check("to4_livre", bus.ocupado, 0);
    esperar_trig(r, ok);
    check("trig4b_ok", ok, 1);
    check("periodo4b", r - r_ant, 8000);
    r_ant = r;
    check("to4_mantido", bus.timeout, 1);
    medida(49, 150, "eco150");

    // 5: echo stuck high -> timeout; a level already high at the next trig is ignored
    esperar_trig(r, ok);
    check("trig5_ok", ok, 1);
    r_ant = r;
    t_tf = n_ciclo;
    timeout_visto = 1'b0;
    n_valido = 0;
    ticks(49);
    bus.echo = 1'b1;
    ticks(6000);
    bus.echo = 1'b0;
    check("to5_visto", timeout_visto, 1);
    check("to5_instante", t_timeout - t_tf, 5000);
    check("to5_sem_valido", n_valido, 0);
    check("to5_dist_mantida", bus.distancia_cm, dist_esp);
    ticks(100);
    bus.echo = 1'b1;
    esperar_trig(r, ok);
    check("trig5b_ok", ok, 1);
    check("periodo5b", r - r_ant, 8000);
    r_ant = r;
    n_valido = 0;
    ticks(300);
    check("nivel_ocupado", bus.ocupado, 1);
    bus.echo = 1'b0;
    ticks(100);
    check("nivel_ignorado", n_valido, 0);
    medida(0, 70, "eco70");

    // 6: reset in the middle of MEDE_ECO
    esperar_trig(r, ok);
    check("trig6_ok", ok, 1);
    ticks(10);
    bus.echo = 1'b1;
    ticks(100);
    check("mede_ocupado", bus.ocupado, 1);
    rst = 1'b1;
    tick();
    check("rst6_trig", bus.trig, 0);
    check("rst6_dist", bus.distancia_cm, 0);
    check("rst6_valido", bus.valido, 0);
    check("rst6_timeout", bus.timeout, 0);
    check("rst6_ocupado", bus.ocupado, 0);
    ticks(2);
    bus.echo = 1'b0;
    rst = 1'b0;
    t_rel = n_ciclo;
    modelo_reset();
    esperar_trig(r, ok);
    check("trig6b_ok", ok, 1);
    check("trig6b_atraso", r - t_rel, 2);
    medida(19, 50, "pos_reset");

`ifdef FILTRO_MEDIA_EN
    // 7: moving average over 20, 20, 40, 40 cm
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    modelo_reset();
    for (int i = 0; i < 4; i++) begin
      esperar_trig(r, ok);
      check("trig7_ok", ok, 1);
      medida(19, larg7[i], "filtro");
      check("filtro_const", bus.distancia_cm, esp7[i]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
